bcd_chain_ctrl: RTL

Sequencing controller for a chain of cascaded 4-bit decade (BCD) counter digits, forming a multi-digit event counter. It owns the digit registers and generates the per-digit Load and Enable strobes. It handles serial preset loading, ripple-carry enabling between digits, terminal-count detection and overflow flagging. It sits between the event source and display/compare logic, replacing ad-hoc wiring of individual decade counters.

---
 rtl/bcd_chain_ctrl_pkg.sv | 15 +
 rtl/bcd_chain_ctrl_if.sv | 33 +++
 rtl/bcd_chain_ctrl_digit.sv | 33 +++
 rtl/bcd_chain_ctrl.sv | 134 +++++++++++++
 4 files changed

// File: rtl/bcd_chain_ctrl_pkg.sv
// Shared types and constants for the cascaded BCD counter chain.
package bcd_ctrl_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_MAX = 4'd9;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/bcd_chain_ctrl_if.sv
// Command/status bundle between the event source and the BCD chain controller.
// Protocol: there is no valid/ready pairing. Every command input (Clear, Stop,
// Preset_load, Start, Count_en) is a level that the controller samples on each
// rising CLK edge. Priority is Clear > Stop > Preset_load > Start. Preset is
// sampled only on the Preset_load edge. Q/Busy/Done/Overflow are registered.
// Dig_load/Dig_en are combinational and describe the coming edge.
interface bcd_chain_ctrl_if #(
  parameter int DIGITS = 4
);
  logic                  Clear;
  logic                  Start;
  logic                  Stop;
  logic                  Preset_load;
  logic [4*DIGITS-1:0]   Preset;
  logic [4*DIGITS-1:0]   Target;
  logic                  Count_en;
  logic [4*DIGITS-1:0]   Q;
  logic [DIGITS-1:0]     Dig_load;
  logic [DIGITS-1:0]     Dig_en;
  logic                  Busy;
  logic                  Done;
  logic                  Overflow;

  modport master (
    output Clear, Start, Stop, Preset_load, Preset, Target, Count_en,
    input  Q, Dig_load, Dig_en, Busy, Done, Overflow
  );

  modport slave (
    input  Clear, Start, Stop, Preset_load, Preset, Target, Count_en,
    output Q, Dig_load, Dig_en, Busy, Done, Overflow
  );
endinterface

// File: rtl/bcd_chain_ctrl_digit.sv
// One decade digit: clear, clamped load, enable-to-increment, carry-out at 9.
module bcd_digit
  import bcd_ctrl_pkg::*;
(
  input  logic       CLK,
  input  logic       MR_n,
  input  logic       clr,
  input  logic       load,
  input  logic       en,
  input  bcd_digit_t d,
  output bcd_digit_t q,
  output bcd_digit_t q_nxt,
  output logic       carry
);

  // carry marks the digit that will roll over; q_nxt is its incremented value
  assign carry = (q == BCD_MAX);
  assign q_nxt = carry ? 4'd0 : q + 4'd1;

  // digit register: clear beats load beats increment; loads saturate at 9
  always_ff @(posedge CLK or negedge MR_n) begin
    if (!MR_n) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (load) begin
      q <= (d > BCD_MAX) ? BCD_MAX : d;
    end else if (en) begin
      q <= q_nxt;
    end
  end

endmodule

// File: rtl/bcd_chain_ctrl.sv
// Sequencing controller for a chain of cascaded BCD digits: serial preset,
// ripple enable, terminal-count compare and sticky overflow.
module bcd_chain_ctrl
  import bcd_ctrl_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                CLK,
  input  logic                MR_n,
  bcd_chain_ctrl_if.slave     bus,
  output state_t              dbg_state
);

  localparam int W  = 4 * DIGITS;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(DIGITS - 1);

  state_t          state;
  logic [IW-1:0]   load_idx;
  logic [W-1:0]    preset_r;
  logic            busy_r, done_r, ovf_r;

  logic [W-1:0]      q, q_inc, q_post;
  logic [DIGITS-1:0] carry, en_mask, load_mask;
  logic              cmd_hold, run_inc, load_cyc, all_nines;
  bcd_digit_t        load_d;

  // Clear or Stop this cycle suppresses any load or count on the coming edge
  assign cmd_hold  = bus.Clear | bus.Stop;
  assign run_inc   = (state == RUN) && bus.Count_en && !cmd_hold;
  assign load_cyc  = (state == LOAD) && !cmd_hold;
  assign all_nines = &carry;
  assign load_d    = preset_r[{load_idx, 2'b00} +: 4];

  // ripple enable: digit i counts only when every lower digit is at 9
  always_comb begin
    logic ripple;
    en_mask   = '0;
    load_mask = '0;
    ripple    = run_inc;
    for (int i = 0; i < DIGITS; i++) begin
      en_mask[i] = ripple;
      ripple     = ripple & carry[i];
    end
    if (load_cyc) load_mask[load_idx] = 1'b1;
  end

  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    bcd_digit u_digit (
      .CLK   (CLK),
      .MR_n  (MR_n),
      .clr   (bus.Clear),
      .load  (load_mask[i]),
      .en    (en_mask[i]),
      .d     (load_d),
      .q     (q[4*i +: 4]),
      .q_nxt (q_inc[4*i +: 4]),
      .carry (carry[i])
    );
    // value the chain will hold after this edge's increment
    assign q_post[4*i +: 4] = en_mask[i] ? q_inc[4*i +: 4] : q[4*i +: 4];
  end

  // control FSM with registered Busy/Done/Overflow
  always_ff @(posedge CLK or negedge MR_n) begin
    if (!MR_n) begin
      state    <= IDLE;
      load_idx <= '0;
      preset_r <= '0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      ovf_r    <= 1'b0;
    end else if (bus.Clear) begin
      state  <= IDLE;
      busy_r <= 1'b0;
      done_r <= 1'b0;
      ovf_r  <= 1'b0;
    end else if (bus.Stop) begin
      state  <= IDLE;
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.Preset_load) begin
            state    <= LOAD;
            busy_r   <= 1'b1;
            preset_r <= bus.Preset;
            load_idx <= '0;
          end else if (bus.Start) begin
            state <= RUN;
          end
        end
        LOAD: begin
          if (load_idx == LAST_IDX) begin
            state  <= IDLE;
            busy_r <= 1'b0;
          end else begin
            load_idx <= load_idx + 1'b1;
          end
        end
        RUN: begin
          if (run_inc) begin
            if (all_nines) ovf_r <= 1'b1;
            if (q_post == bus.Target) begin
              state  <= DONE;
              done_r <= 1'b1;
            end
          end
        end
        DONE: begin
          if (bus.Start) begin
            state  <= RUN;
            done_r <= 1'b0;
          end
        end
        default: begin
          state  <= IDLE;
          busy_r <= 1'b0;
          done_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.Q        = q;
  assign bus.Dig_load = load_mask;
  assign bus.Dig_en   = en_mask;
  assign bus.Busy     = busy_r;
  assign bus.Done     = done_r;
  assign bus.Overflow = ovf_r;
  assign dbg_state    = state;

endmodule
